// File: rtl/msg_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : msg_display_pkg
//  Description : Shared letter codes, word encodings and word ROM for the
//                4-digit status-message display path.
//  Revision    : 1.0 - initial release
// ============================================================================
package msg_display_pkg;

  // Letter codes understood by the downstream 7-segment letter decoder
  localparam logic [3:0] LTR_F     = 4'd0;
  localparam logic [3:0] LTR_R     = 4'd1;
  localparam logic [3:0] LTR_E     = 4'd2;
  localparam logic [3:0] LTR_P     = 4'd3;
  localparam logic [3:0] LTR_A     = 4'd4;
  localparam logic [3:0] LTR_O     = 4'd5;
  localparam logic [3:0] LTR_U     = 4'd6;
  localparam logic [3:0] LTR_L     = 4'd7;
  localparam logic [3:0] LTR_BLANK = 4'hF;

  // Status words selectable by the host
  typedef enum logic [1:0] {
    WORD_FREE = 2'd0,
    WORD_PARE = 2'd1,
    WORD_ERRO = 2'd2,
    WORD_FULL = 2'd3
  } word_t;

  // Blink phase of the whole display
  typedef enum logic {
    PHASE_VISIBLE = 1'b0,
    PHASE_HIDDEN  = 1'b1
  } phase_t;

  // Letter shown at a given digit position (0 = leftmost) of a word
  function automatic logic [3:0] word_letter(input word_t word, input logic [1:0] idx);
    logic [3:0] code;
    code = LTR_BLANK;
    case (word)
      WORD_FREE: case (idx)
        2'd0: code = LTR_F;
        2'd1: code = LTR_R;
        default: code = LTR_E;
      endcase
      WORD_PARE: case (idx)
        2'd0: code = LTR_P;
        2'd1: code = LTR_A;
        2'd2: code = LTR_R;
        default: code = LTR_E;
      endcase
      WORD_ERRO: case (idx)
        2'd0: code = LTR_E;
        2'd1: code = LTR_R;
        2'd2: code = LTR_R;
        default: code = LTR_O;
      endcase
      default: case (idx)
        2'd0: code = LTR_F;
        2'd1: code = LTR_U;
        default: code = LTR_L;
      endcase
    endcase
    return code;
  endfunction

  // Active-low one-cold digit enable; bit 3 drives the leftmost digit
  function automatic logic [3:0] digit_enable(input logic [1:0] idx);
    logic [3:0] en_n;
    case (idx)
      2'd0: en_n = 4'b0111;
      2'd1: en_n = 4'b1011;
      2'd2: en_n = 4'b1101;
      default: en_n = 4'b1110;
    endcase
    return en_n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scan_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : scan_tick_gen
//  Description : Free-running prescaler; tick is high for one cycle out of
//                every SCAN_DIV cycles (the cycle the count is SCAN_DIV-1).
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_tick_gen #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] count;

  // Count 0..SCAN_DIV-1 and wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (count == CNT_MAX) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/message_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : message_scan_ctrl
//  Description : Holds the active status word and time-multiplexes its four
//                letters onto the letter-code bus with active-low digit
//                enables. Word changes take effect only at frame boundaries;
//                optional whole-display blinking.
//  Revision    : 1.0 - initial release
// ============================================================================
module message_scan_ctrl
  import msg_display_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] word_sel,
  input  logic       word_load,
  input  logic       blink_en,
  output logic [3:0] letter_code,
  output logic [3:0] digit_en_n,
  output logic       load_ack,
  output logic       frame_start
);

  localparam int BLK_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_FRAMES - 1);

  logic             tick;
  logic             frame_wrap;
  logic [1:0]       digit_idx;
  word_t            active_word;
  word_t            pending_word;
  logic             pending_valid;
  logic [BLK_W-1:0] blink_cnt;
  phase_t           blink_phase;

  scan_tick_gen #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // A frame ends on the tick that moves the index off the last digit
  assign frame_wrap = tick && (digit_idx == 2'd3);

  // Digit scanning, pending-word capture and frame-aligned word switch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_idx     <= 2'd0;
      active_word   <= WORD_FREE;
      pending_word  <= WORD_FREE;
      pending_valid <= 1'b0;
      load_ack      <= 1'b0;
      frame_start   <= 1'b0;
    end else begin
      frame_start <= frame_wrap;
      load_ack    <= frame_wrap && pending_valid;
      if (tick) begin
        digit_idx <= digit_idx + 2'd1;
      end
      if (frame_wrap && pending_valid) begin
        active_word   <= pending_word;
        pending_valid <= 1'b0;
      end
      // A load in the wrap cycle itself is queued for the following frame
      if (word_load) begin
        pending_word  <= word_t'(word_sel);
        pending_valid <= 1'b1;
      end
    end
  end

  // Blink phase machine: toggles every BLINK_FRAMES frames while enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= PHASE_VISIBLE;
    end else if (!blink_en) begin
      blink_cnt   <= '0;
      blink_phase <= PHASE_VISIBLE;
    end else if (frame_wrap) begin
      if (blink_cnt == BLK_MAX) begin
        blink_cnt   <= '0;
        blink_phase <= (blink_phase == PHASE_VISIBLE) ? PHASE_HIDDEN : PHASE_VISIBLE;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Display drive from registered state; blink_en gates so blanking drops instantly
  always_comb begin
    letter_code = word_letter(active_word, digit_idx);
    digit_en_n  = digit_enable(digit_idx);
    if (blink_en && (blink_phase == PHASE_HIDDEN)) begin
      letter_code = LTR_BLANK;
      digit_en_n  = 4'b1111;
    end
  end

endmodule
`default_nettype wire

// File: doc/message_scan_ctrl.md
Name: message_scan_ctrl

Overview:
- Upstream stage of the 4-bit letter decoder that drives a 4-digit multiplexed 7-segment display.
- Holds the active status word (FrEE, PArE, ErrO, FULL) and time-multiplexes its four letters onto a single letter-code bus with matching active-low digit enables.
- Word changes are applied only at frame boundaries so no frame shows a mix of two words.
- Optional blinking of the whole display.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot (must be at least 2).
- BLINK_FRAMES, 64, full frames per blink half-period (must be at least 1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- word_sel  in  2  requested word: 0=FrEE, 1=PArE, 2=ErrO, 3=FULL
- word_load  in  1  one-cycle strobe; captures word_sel as pending
- blink_en  in  1  level; 1 = blink display
- letter_code  out  4  letter code to the decoder: F=0, r=1, E=2, P=3, A=4, O=5, U=6, L=7, blank=4'hF
- digit_en_n  out  4  active-low digit enables; bit 3 = leftmost digit
- load_ack  out  1  one-cycle pulse when a pending word becomes active
- frame_start  out  1  one-cycle pulse when the digit index wraps 3->0

Behaviour:
- Reset is asynchronous and active-low; one clock domain.
- Reset state:
  - prescaler = 0, digit index = 0, active word = FrEE, no pending word.
  - blink frame counter = 0, blink phase = visible.
  - load_ack = 0, frame_start = 0.
- Reset outputs: letter_code = 0, digit_en_n = 4'b0111.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick is asserted in the cycle the prescaler equals SCAN_DIV-1.
- Digit index:
  - Advances on tick: 0->1->2->3->0.
  - Enable mapping: index 0 -> 4'b0111, 1 -> 4'b1011, 2 -> 4'b1101, 3 -> 4'b1110.
  - Exactly one enable bit is low whenever the display is visible.
- Word ROM, letter per index 0..3:
  - FrEE = 0,1,2,2
  - PArE = 3,4,1,2
  - ErrO = 2,1,1,5
  - FULL = 0,6,7,7
- Output timing: letter_code and digit_en_n are a combinational function of registered state only (active word, index, blink phase, blink_en). No input-to-output combinational path except blink_en gating.
- Pending word:
  - word_load captures word_sel into the pending register and sets the pending flag.
  - A second load before application overwrites the pending value; last load wins and only one load_ack is produced.
- Frame boundary (tick with index 3):
  - Index becomes 0.
  - frame_start pulses in the following cycle, aligned with index 0.
  - If the pending flag was set before this cycle: active word <= pending value, pending flag cleared, load_ack pulses in the following cycle.
  - A word_load arriving in the wrap cycle itself becomes pending for the next frame.
- Blink:
  - While blink_en = 0: frame counter is held at 0 and phase at visible.
  - While blink_en = 1: the frame counter increments on each frame boundary; at BLINK_FRAMES-1 it wraps and the phase toggles.
  - Hidden phase with blink_en = 1: letter_code = 4'hF and digit_en_n = 4'b1111.
  - Deasserting blink_en restores visibility immediately (combinational).
  - Scanning and word application continue during hidden phases.
- Reset mid-operation: all state returns to reset values immediately; any pending word is discarded.

Decomposition:
- Shared package, msg_display_pkg:
  - letter-code constants (F, r, E, P, A, O, U, L, BLANK);
  - word_sel encodings;
  - word-ROM function (word, index) -> letter code.
- The decoder stage imports the same letter constants.
- One natural sub-module: scan_tick_gen (prescaler, parameterised by SCAN_DIV, output tick).

Test Plan (SCAN_DIV=4, BLINK_FRAMES=2):
- Release reset, no loads -> letter_code sequence 0,1,2,2 repeating; each digit held 4 cycles; digit_en_n sequence 0111, 1011, 1101, 1110; frame_start every 16 cycles.
- word_load with word_sel=1 while index 1 -> display stays FrEE to end of frame; at the next index 0, load_ack pulses once and codes become 3,4,1,2.
- Loads word_sel=2 then word_sel=3 within one frame -> single load_ack; next frame shows 0,6,7,7.
- word_load exactly in the wrap cycle -> current wrap keeps the old word; the word is applied one frame later with load_ack.
- blink_en=1 -> 2 frames visible, then 2 frames with letter_code=4'hF and digit_en_n=1111, repeating; dropping blink_en while hidden restores output in the same cycle.
- Assert rst_n low mid-frame while a load is pending -> outputs immediately 0 / 0111; after release FrEE is shown and no load_ack occurs.
